idex_stage_reg: RTL and testbench
=================================

Name: idex_stage_reg

Overview:
- Clocked, parametrised ID/EX pipeline register that sits between decode/register-file read and the EX stage.
- Carries a valid bit alongside the control, operand, immediate, funct and source-register fields.
- Supports flush, downstream stall (hold), and automatic load-use bubble insertion, reporting the resulting stall to decode.
- Pre-computes the effective address (imm + RD2) for ALUSrc ops and keeps saturating flush and bubble counters for performance debug.

Parameters:
DATA_W, 16, width of RD1/RD2/immediate/address datapath
REG_AW, 4, register-specifier width
FUNCT_W, 4, funct-code width
ALUOP_W, 2, ALU-op control width
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-high
id_valid  in  1  decode presents a valid instruction
flush  in  1  squash the instruction entering EX (branch taken/exception)
ex_stall  in  1  EX cannot advance; hold register contents
rd1_in, rd2_in  in  DATA_W  register-file read data
imm_in  in  DATA_W  sign-extended immediate
funct_in  in  FUNCT_W  funct code
rs_in, rt_in  in  REG_AW  decode source specifiers
r15_in, alusrc_in, memtoreg_in, regwrite_in, memread_in, memwrite_in, branch_in  in  1 each  control
aluop_in  in  ALUOP_W  ALU op class
ex_valid  out  1  registered valid
r15_out, alusrc_out, memtoreg_out, regwrite_out, memread_out, memwrite_out, branch_out  out  1 each  registered control
aluop_out  out  ALUOP_W  registered ALU op
rd1_out, rd2_out  out  DATA_W  registered operands
imm_addr_out  out  DATA_W  imm_in+rd2_in if alusrc_in, else imm_in (registered)
funct_out  out  FUNCT_W
rs_out, rt_out  out  REG_AW  registered specifiers for forwarding unit
id_stall  out  1  combinational: decode/fetch must hold
flush_cnt, bubble_cnt  out  CNT_W  saturating counters

Behaviour:
- Reset (async, immediate on assertion): every registered output and both counters go to 0. First update occurs on the first clk edge after rst deasserts.
- load_use = ex_valid & memread_out & id_valid & ((rt_out==rs_in) | (rt_out==rt_in)).
- id_stall = ~flush & (ex_stall | load_use).
- Per-edge priority, highest first:
  1. flush: load bubble (ex_valid and all outputs 0). flush_cnt += 1.
  2. ex_stall: hold every register unchanged. No counter change.
  3. load_use: load bubble. bubble_cnt += 1. Decode holds because id_stall=1.
  4. id_valid=0: load bubble. No counter change.
  5. Otherwise: capture all inputs, set ex_valid=1, and compute imm_addr_out.
- Latency: 1 cycle from capture to outputs.
- A load-use hazard costs exactly one bubble; the following cycle ex_valid=0, so the hazard clears and the held instruction loads.
- Bubble: every control bit 0, so no RegWrite, MemWrite or Branch side effects downstream. Data fields are also 0 for deterministic traces.
- Address arithmetic: unsigned DATA_W add, carry discarded (modulo 2^DATA_W).
- Counters saturate at all-ones with no wrap. They clear only on rst.
- Simultaneous flush + ex_stall: flush wins, register is squashed.
- Simultaneous flush + load_use: counts as a flush only; id_stall=0.
- rst asserted mid-stall or mid-bubble: state clears immediately, with no residual stall.

Test Plan:
- Reset: assert rst asynchronously between edges, expecting all outputs 0 immediately. Then release rst, drive id_valid=1, rd1_in=16'h1234, rd2_in=16'h0010, imm_in=16'h0004, alusrc_in=1, regwrite_in=1. Next edge must give ex_valid=1, rd1_out=16'h1234, imm_addr_out=16'h0014, regwrite_out=1.
- Wrap: alusrc_in=1, rd2_in=16'hFFFE, imm_in=16'h0003 -> imm_addr_out=16'h0001. With alusrc_in=0, imm_addr_out=16'h0003.
- Load-use: load memread_in=1 with rt_in=4'd5. Next cycle present rs_in=4'd5, expecting id_stall=1 and that edge to give ex_valid=0, all control 0, bubble_cnt=1. The following edge captures the held instruction with id_stall=0.
- Stall hold: with a valid entry loaded, hold ex_stall=1 for 3 cycles while inputs change. Outputs must stay unchanged, id_stall=1, and counters unchanged.
- Flush priority: assert flush+ex_stall+load_use together, expecting next edge ex_valid=0, flush_cnt +1, bubble_cnt unchanged, id_stall=0.
- Saturation (CNT_W=2): four consecutive flushes -> flush_cnt=3 and it stays 3.

Source files
------------

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register: carries one decoded instruction into EX, inserting bubbles on
// flush, load-use hazards or empty decode slots, and holding contents while EX is stalled.
module idex_stage_reg #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4,
    parameter int FUNCT_W = 4,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic               flush,
    input  logic               ex_stall,
    input  logic [DATA_W-1:0]  rd1_in,
    input  logic [DATA_W-1:0]  rd2_in,
    input  logic [DATA_W-1:0]  imm_in,
    input  logic [FUNCT_W-1:0] funct_in,
    input  logic [REG_AW-1:0]  rs_in,
    input  logic [REG_AW-1:0]  rt_in,
    input  logic               r15_in,
    input  logic               alusrc_in,
    input  logic               memtoreg_in,
    input  logic               regwrite_in,
    input  logic               memread_in,
    input  logic               memwrite_in,
    input  logic               branch_in,
    input  logic [ALUOP_W-1:0] aluop_in,
    output logic               ex_valid,
    output logic               r15_out,
    output logic               alusrc_out,
    output logic               memtoreg_out,
    output logic               regwrite_out,
    output logic               memread_out,
    output logic               memwrite_out,
    output logic               branch_out,
    output logic [ALUOP_W-1:0] aluop_out,
    output logic [DATA_W-1:0]  rd1_out,
    output logic [DATA_W-1:0]  rd2_out,
    output logic [DATA_W-1:0]  imm_addr_out,
    output logic [FUNCT_W-1:0] funct_out,
    output logic [REG_AW-1:0]  rs_out,
    output logic [REG_AW-1:0]  rt_out,
    output logic               id_stall,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    logic              load_use;
    logic              load_bubble;
    logic              capture;
    logic [DATA_W-1:0] imm_addr_next;

    // Handshake with decode: id_valid is decode's offer; id_stall=1 means the offer was
    // not taken this edge and decode must present the same instruction again.
    assign load_use = ex_valid & memread_out & id_valid &
                      ((rt_out == rs_in) | (rt_out == rt_in));
    assign id_stall = ~flush & (ex_stall | load_use);

    assign load_bubble = flush | (~ex_stall & (load_use | ~id_valid));
    assign capture     = ~flush & ~ex_stall & ~load_use & id_valid;

    // Carry out of the address add is intentionally dropped.
    assign imm_addr_next = alusrc_in ? (imm_in + rd2_in) : imm_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            r15_out      <= 1'b0;
            alusrc_out   <= 1'b0;
            memtoreg_out <= 1'b0;
            regwrite_out <= 1'b0;
            memread_out  <= 1'b0;
            memwrite_out <= 1'b0;
            branch_out   <= 1'b0;
            aluop_out    <= '0;
            rd1_out      <= '0;
            rd2_out      <= '0;
            imm_addr_out <= '0;
            funct_out    <= '0;
            rs_out       <= '0;
            rt_out       <= '0;
        end else if (load_bubble) begin
            ex_valid     <= 1'b0;
            r15_out      <= 1'b0;
            alusrc_out   <= 1'b0;
            memtoreg_out <= 1'b0;
            regwrite_out <= 1'b0;
            memread_out  <= 1'b0;
            memwrite_out <= 1'b0;
            branch_out   <= 1'b0;
            aluop_out    <= '0;
            rd1_out      <= '0;
            rd2_out      <= '0;
            imm_addr_out <= '0;
            funct_out    <= '0;
            rs_out       <= '0;
            rt_out       <= '0;
        end else if (capture) begin
            ex_valid     <= 1'b1;
            r15_out      <= r15_in;
            alusrc_out   <= alusrc_in;
            memtoreg_out <= memtoreg_in;
            regwrite_out <= regwrite_in;
            memread_out  <= memread_in;
            memwrite_out <= memwrite_in;
            branch_out   <= branch_in;
            aluop_out    <= aluop_in;
            rd1_out      <= rd1_in;
            rd2_out      <= rd2_in;
            imm_addr_out <= imm_addr_next;
            funct_out    <= funct_in;
            rs_out       <= rs_in;
            rt_out       <= rt_in;
        end
    end

    // Saturating performance counters; a flush that coincides with a hazard counts only as a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (!flush && !ex_stall && load_use && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_idex_stage_reg.sv
// Bench for idex_stage_reg: directed scenarios plus random traffic against a slot-level model.
`timescale 1ns/1ps
module tb_idex_stage_reg;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int FW = 4;
  localparam int OW = 2;
  localparam int BW = 8 + OW + 3*DW + FW + 2*AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          id_valid, flush, ex_stall;
  logic [DW-1:0] rd1_in, rd2_in, imm_in;
  logic [FW-1:0] funct_in;
  logic [AW-1:0] rs_in, rt_in;
  logic          r15_in, alusrc_in, memtoreg_in, regwrite_in, memread_in, memwrite_in, branch_in;
  logic [OW-1:0] aluop_in;

  logic          ex_valid, r15_out, alusrc_out, memtoreg_out, regwrite_out, memread_out, memwrite_out, branch_out;
  logic [OW-1:0] aluop_out;
  logic [DW-1:0] rd1_out, rd2_out, imm_addr_out;
  logic [FW-1:0] funct_out;
  logic [AW-1:0] rs_out, rt_out;
  logic          id_stall;
  logic [15:0]   flush_cnt, bubble_cnt;

  logic          s_ex_valid, s_r15, s_alusrc, s_memtoreg, s_regwrite, s_memread, s_memwrite, s_branch;
  logic [OW-1:0] s_aluop;
  logic [DW-1:0] s_rd1, s_rd2, s_addr;
  logic [FW-1:0] s_funct;
  logic [AW-1:0] s_rs, s_rt;
  logic          s_id_stall;
  logic [1:0]    s_flush_cnt, s_bubble_cnt;

  idex_stage_reg dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush), .ex_stall(ex_stall),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in), .funct_in(funct_in),
    .rs_in(rs_in), .rt_in(rt_in), .r15_in(r15_in), .alusrc_in(alusrc_in),
    .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in), .memread_in(memread_in),
    .memwrite_in(memwrite_in), .branch_in(branch_in), .aluop_in(aluop_in),
    .ex_valid(ex_valid), .r15_out(r15_out), .alusrc_out(alusrc_out),
    .memtoreg_out(memtoreg_out), .regwrite_out(regwrite_out), .memread_out(memread_out),
    .memwrite_out(memwrite_out), .branch_out(branch_out), .aluop_out(aluop_out),
    .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_addr_out(imm_addr_out),
    .funct_out(funct_out), .rs_out(rs_out), .rt_out(rt_out), .id_stall(id_stall),
    .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
  );

  idex_stage_reg #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush), .ex_stall(ex_stall),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in), .funct_in(funct_in),
    .rs_in(rs_in), .rt_in(rt_in), .r15_in(r15_in), .alusrc_in(alusrc_in),
    .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in), .memread_in(memread_in),
    .memwrite_in(memwrite_in), .branch_in(branch_in), .aluop_in(aluop_in),
    .ex_valid(s_ex_valid), .r15_out(s_r15), .alusrc_out(s_alusrc),
    .memtoreg_out(s_memtoreg), .regwrite_out(s_regwrite), .memread_out(s_memread),
    .memwrite_out(s_memwrite), .branch_out(s_branch), .aluop_out(s_aluop),
    .rd1_out(s_rd1), .rd2_out(s_rd2), .imm_addr_out(s_addr),
    .funct_out(s_funct), .rs_out(s_rs), .rt_out(s_rt), .id_stall(s_id_stall),
    .flush_cnt(s_flush_cnt), .bubble_cnt(s_bubble_cnt)
  );

  logic [BW-1:0] obs, s_obs, exp_bus;
  assign obs = {ex_valid, r15_out, alusrc_out, memtoreg_out, regwrite_out, memread_out, memwrite_out,
                branch_out, aluop_out, rd1_out, rd2_out, imm_addr_out, funct_out, rs_out, rt_out};
  assign s_obs = {s_ex_valid, s_r15, s_alusrc, s_memtoreg, s_regwrite, s_memread, s_memwrite,
                  s_branch, s_aluop, s_rd1, s_rd2, s_addr, s_funct, s_rs, s_rt};

  // Model of the EX slot: ctl bits ordered r15, alusrc, memtoreg, regwrite, memread, memwrite, branch.
  logic          m_valid;
  logic [6:0]    m_ctl;
  logic [OW-1:0] m_aluop;
  logic [DW-1:0] m_rd1, m_rd2, m_addr;
  logic [FW-1:0] m_funct;
  logic [AW-1:0] m_rs, m_rt;
  int            fc, bc;
  assign exp_bus = {m_valid, m_ctl, m_aluop, m_rd1, m_rd2, m_addr, m_funct, m_rs, m_rt};

  int total = 0;
  int bad = 0;

  function automatic int sat(int v, int m);
    return (v > m) ? m : v;
  endfunction

  // Decode's instruction reads the register the load in EX is about to produce.
  function automatic logic hazard();
    return m_valid && m_ctl[2] && id_valid && (m_rt == rs_in || m_rt == rt_in);
  endfunction

  function automatic logic exp_stall();
    return !flush && (ex_stall || hazard());
  endfunction

  task automatic clear_model();
    m_valid = 0; m_ctl = '0; m_aluop = '0; m_rd1 = '0; m_rd2 = '0;
    m_addr = '0; m_funct = '0; m_rs = '0; m_rt = '0;
  endtask

  task automatic clear_inputs();
    id_valid = 0; flush = 0; ex_stall = 0; rd1_in = '0; rd2_in = '0; imm_in = '0;
    funct_in = '0; rs_in = '0; rt_in = '0; r15_in = 0; alusrc_in = 0; memtoreg_in = 0;
    regwrite_in = 0; memread_in = 0; memwrite_in = 0; branch_in = 0; aluop_in = '0;
  endtask

  task automatic random_instr();
    id_valid = 1; rd1_in = DW'($urandom); rd2_in = DW'($urandom); imm_in = DW'($urandom);
    funct_in = FW'($urandom); rs_in = AW'($urandom_range(0, 3)); rt_in = AW'($urandom_range(0, 3));
    r15_in = 1'($urandom); alusrc_in = 1'($urandom); memtoreg_in = 1'($urandom);
    regwrite_in = 1'($urandom); memread_in = ($urandom_range(0, 2) == 0);
    memwrite_in = 1'($urandom); branch_in = 1'($urandom); aluop_in = OW'($urandom);
  endtask

  // Advance one edge, applying the slot priority rules to the model.
  task automatic tick();
    if (flush) begin
      clear_model(); fc++;
    end else if (ex_stall) begin
      // slot holds
    end else if (hazard()) begin
      clear_model(); bc++;
    end else if (!id_valid) begin
      clear_model();
    end else begin
      m_valid = 1;
      m_ctl = {r15_in, alusrc_in, memtoreg_in, regwrite_in, memread_in, memwrite_in, branch_in};
      m_aluop = aluop_in; m_rd1 = rd1_in; m_rd2 = rd2_in; m_funct = funct_in;
      m_rs = rs_in; m_rt = rt_in;
      m_addr = alusrc_in ? DW'((int'(imm_in) + int'(rd2_in)) % 65536) : imm_in;
    end
    @(posedge clk);
    #1;
  endtask

  // Asserts rst midway between edges and releases it before the next edge.
  task automatic pulse_reset();
    #2; rst = 1; clear_model(); fc = 0; bc = 0;
    #2; rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs(); clear_model(); fc = 0; bc = 0;
    #1 rst = 1;
    #1;
    total++; if (obs !== '0) begin bad++; $display("FAIL reset_regs got=%h exp=0", obs); end
    total++; if (flush_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_cnt got=%h/%h exp=0/0", flush_cnt, bubble_cnt); end
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", id_stall); end
    #1 rst = 0;
    id_valid = 1; rd1_in = 16'h1234; rd2_in = 16'h0010; imm_in = 16'h0004;
    alusrc_in = 1; regwrite_in = 1;
    tick();
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", ex_valid); end
    total++; if (rd1_out !== 16'h1234) begin bad++; $display("FAIL first_rd1 got=%h exp=1234", rd1_out); end
    total++; if (imm_addr_out !== 16'h0014) begin bad++; $display("FAIL first_addr got=%h exp=0014", imm_addr_out); end
    total++; if (regwrite_out !== 1'b1) begin bad++; $display("FAIL first_regwrite got=%b exp=1", regwrite_out); end
    total++; if (obs !== exp_bus) begin bad++; $display("FAIL first_all got=%h exp=%h", obs, exp_bus); end
  endtask

  task automatic test_wrap();
    clear_inputs();
    id_valid = 1; alusrc_in = 1; rd2_in = 16'hFFFE; imm_in = 16'h0003;
    tick();
    total++; if (imm_addr_out !== 16'h0001) begin bad++; $display("FAIL wrap_add got=%h exp=0001", imm_addr_out); end
    alusrc_in = 0;
    tick();
    total++; if (imm_addr_out !== 16'h0003) begin bad++; $display("FAIL wrap_noadd got=%h exp=0003", imm_addr_out); end
    total++; if (obs !== exp_bus) begin bad++; $display("FAIL wrap_all got=%h exp=%h", obs, exp_bus); end
  endtask

  task automatic test_load_use();
    int bc0;
    clear_inputs(); tick();
    id_valid = 1; memread_in = 1; memtoreg_in = 1; regwrite_in = 1; rt_in = 4'd5; rs_in = 4'd2;
    tick();
    bc0 = bc;
    clear_inputs(); id_valid = 1; rs_in = 4'd5; rt_in = 4'd1; regwrite_in = 1; rd1_in = 16'hBEEF;
    #1;
    total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", id_stall); end
    tick();
    total++; if (obs !== '0) begin bad++; $display("FAIL lu_bubble got=%h exp=0", obs); end
    total++; if (bubble_cnt !== 16'(bc0 + 1)) begin bad++; $display("FAIL lu_cnt got=%0d exp=%0d", bubble_cnt, bc0 + 1); end
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL lu_release got=%b exp=0", id_stall); end
    tick();
    total++; if (ex_valid !== 1'b1 || rs_out !== 4'd5 || rd1_out !== 16'hBEEF) begin
      bad++; $display("FAIL lu_reload got=%b/%h/%h exp=1/5/beef", ex_valid, rs_out, rd1_out); end
    total++; if (obs !== exp_bus) begin bad++; $display("FAIL lu_all got=%h exp=%h", obs, exp_bus); end
  endtask

  task automatic test_stall_hold();
    logic [BW-1:0] held;
    logic [15:0]   f0, b0;
    clear_inputs(); random_instr(); memread_in = 0;
    tick();
    held = exp_bus; f0 = flush_cnt; b0 = bubble_cnt;
    for (int i = 0; i < 3; i++) begin
      random_instr(); ex_stall = 1;
      #1;
      total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL hold_stall[%0d] got=%b exp=1", i, id_stall); end
      tick();
      total++; if (obs !== held) begin bad++; $display("FAIL hold_regs[%0d] got=%h exp=%h", i, obs, held); end
      total++; if (flush_cnt !== f0 || bubble_cnt !== b0) begin
        bad++; $display("FAIL hold_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, flush_cnt, bubble_cnt, f0, b0); end
    end
  endtask

  task automatic test_flush_priority();
    int f0, b0;
    clear_inputs(); tick();
    id_valid = 1; memread_in = 1; rt_in = 4'd7; tick();
    f0 = fc; b0 = bc;
    clear_inputs(); id_valid = 1; rs_in = 4'd7; flush = 1; ex_stall = 1; regwrite_in = 1;
    #1;
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL fp_stall got=%b exp=0", id_stall); end
    tick();
    total++; if (ex_valid !== 1'b0 || obs !== '0) begin bad++; $display("FAIL fp_squash got=%h exp=0", obs); end
    total++; if (flush_cnt !== 16'(f0 + 1) || bubble_cnt !== 16'(b0)) begin
      bad++; $display("FAIL fp_cnt got=%0d/%0d exp=%0d/%0d", flush_cnt, bubble_cnt, f0 + 1, b0); end
  endtask

  task automatic test_reset_mid();
    clear_inputs(); random_instr(); memread_in = 0; tick();
    ex_stall = 1; tick();
    #2 rst = 1; clear_model(); fc = 0; bc = 0; ex_stall = 0;
    #1;
    total++; if (obs !== '0 || flush_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid_stall got=%h exp=0", obs); end
    #1 rst = 0;
    clear_inputs(); id_valid = 1; memread_in = 1; rt_in = 4'd5; tick();
    rs_in = 4'd5; memread_in = 0;
    #1;
    total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL rst_pre_hz got=%b exp=1", id_stall); end
    rst = 1; clear_model(); fc = 0; bc = 0;
    #1;
    total++; if (id_stall !== 1'b0 || ex_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_bubble got=%b/%b exp=0/0", id_stall, ex_valid); end
    #1 rst = 0;
    tick();
    total++; if (ex_valid !== 1'b1 || bubble_cnt !== 16'd0) begin
      bad++; $display("FAIL rst_after got=%b/%0d exp=1/0", ex_valid, bubble_cnt); end
  endtask

  task automatic test_saturation();
    pulse_reset();
    clear_inputs();
    for (int i = 1; i <= 5; i++) begin
      flush = 1; tick();
      total++; if (s_flush_cnt !== 2'(sat(i, 3))) begin
        bad++; $display("FAIL sat_flush[%0d] got=%0d exp=%0d", i, s_flush_cnt, sat(i, 3)); end
      total++; if (flush_cnt !== 16'(i)) begin bad++; $display("FAIL wide_flush[%0d] got=%0d exp=%0d", i, flush_cnt, i); end
    end
    flush = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clear_inputs();
      if ($urandom_range(0, 9) != 0) random_instr();
      flush = ($urandom_range(0, 15) == 0);
      ex_stall = ($urandom_range(0, 7) == 0);
      #1;
      total++; if (id_stall !== exp_stall()) begin bad++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", i, id_stall, exp_stall()); end
      tick();
      total++; if (obs !== exp_bus) begin bad++; $display("FAIL rnd_regs[%0d] got=%h exp=%h", i, obs, exp_bus); end
      total++; if (s_obs !== exp_bus) begin bad++; $display("FAIL rnd_sregs[%0d] got=%h exp=%h", i, s_obs, exp_bus); end
      total++; if (flush_cnt !== 16'(sat(fc, 65535)) || bubble_cnt !== 16'(sat(bc, 65535))) begin
        bad++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, flush_cnt, bubble_cnt, fc, bc); end
      total++; if (s_flush_cnt !== 2'(sat(fc, 3)) || s_bubble_cnt !== 2'(sat(bc, 3))) begin
        bad++; $display("FAIL rnd_scnt[%0d] got=%0d/%0d exp=%0d/%0d", i, s_flush_cnt, s_bubble_cnt, sat(fc, 3), sat(bc, 3)); end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_load_use();
    test_stall_hold();
    test_flush_priority();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
